// File: rtl/pong_pkg.sv
// Shared VGA timing, colour and geometry constants for the pong game core and its renderer.
package pong_pkg;

   localparam int H_ACTIVE      = 640;
   localparam int H_FP          = 16;
   localparam int H_SYNC        = 96;
   localparam int H_BP          = 48;
   localparam int H_TOTAL       = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int H_SYNC_START  = H_ACTIVE + H_FP;
   localparam int H_SYNC_END    = H_SYNC_START + H_SYNC;

   localparam int V_ACTIVE      = 480;
   localparam int V_FP          = 10;
   localparam int V_SYNC        = 2;
   localparam int V_BP          = 33;
   localparam int V_TOTAL       = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int V_SYNC_START  = V_ACTIVE + V_FP;
   localparam int V_SYNC_END    = V_SYNC_START + V_SYNC;

   localparam int PADDLE_WIDTH  = 10;
   localparam int PADDLE_HEIGHT = 60;
   localparam int BALL_SIZE     = 10;

   localparam logic [5:0] RGB_BLACK  = 6'b000000;
   localparam logic [5:0] RGB_BALL   = 6'b111100;
   localparam logic [5:0] RGB_PADDLE = 6'b111111;
   localparam logic [5:0] RGB_NET    = 6'b010101;
   localparam logic [5:0] RGB_SCORE  = 6'b001100;

   localparam logic [9:0] BALL_X_RST   = 10'd320;
   localparam logic [9:0] BALL_Y_RST   = 10'd240;
   localparam logic [9:0] PADDLE_Y_RST = 10'd210;

   typedef struct packed {
      logic [9:0] ply_y;
      logic [9:0] opp_y;
      logic [9:0] bx;
      logic [9:0] by;
      logic [7:0] score;
   } game_state_t;

   // 11-bit compare so lo+len never wraps at the top of the 10-bit range.
   function automatic logic in_span(input logic [10:0] pos, input logic [10:0] lo,
                                    input logic [10:0] len);
      return (pos >= lo) && (pos < (lo + len));
   endfunction

endpackage

// File: rtl/pong_vga_renderer_if.sv
// Game-state link between the pong game core (master) and the VGA renderer (slave).
interface pong_vga_renderer_if;
   logic [9:0] player_paddle_y;
   logic [9:0] opponent_paddle_y;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic [7:0] score;
   logic       frame_tick;

   modport master (
      output player_paddle_y, opponent_paddle_y, ball_x, ball_y, score,
      input  frame_tick
   );

   modport slave (
      input  player_paddle_y, opponent_paddle_y, ball_x, ball_y, score,
      output frame_tick
   );
endinterface

// File: rtl/vga_timing.sv
// VGA pixel/line counters with raw sync, active-area flag and start-of-vblank strobes.
module vga_timing
   import pong_pkg::*;
#(
   parameter int H_ACT   = H_ACTIVE,
   parameter int H_FRONT = H_FP,
   parameter int H_SW    = H_SYNC,
   parameter int H_BACK  = H_BP,
   parameter int V_ACT   = V_ACTIVE,
   parameter int V_FRONT = V_FP,
   parameter int V_SW    = V_SYNC,
   parameter int V_BACK  = V_BP
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_en,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       hsync_raw,
   output logic       vsync_raw,
   output logic       active_raw,
   output logic       snap,
   output logic       frame_tick
);

   localparam int H_TOT = H_ACT + H_FRONT + H_SW + H_BACK;
   localparam int V_TOT = V_ACT + V_FRONT + V_SW + V_BACK;

   logic [9:0] hcount_r;
   logic [9:0] vcount_r;
   logic       frame_tick_r;
   logic       h_wrap_s;
   logic       v_wrap_s;

   assign h_wrap_s = (hcount_r == 10'(H_TOT - 1));
   assign v_wrap_s = (vcount_r == 10'(V_TOT - 1));
   // True on the step that moves the counters onto (0, V_ACT).
   assign snap     = h_wrap_s && (vcount_r == 10'(V_ACT - 1));

   // Counter advance and one-clk frame strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hcount_r     <= 10'd0;
         vcount_r     <= 10'd0;
         frame_tick_r <= 1'b0;
      end else if (pix_en) begin
         frame_tick_r <= snap;
         if (h_wrap_s) begin
            hcount_r <= 10'd0;
            vcount_r <= v_wrap_s ? 10'd0 : (vcount_r + 10'd1);
         end else begin
            hcount_r <= hcount_r + 10'd1;
         end
      end else begin
         frame_tick_r <= 1'b0;
      end
   end

   assign hsync_raw  = !((hcount_r >= 10'(H_ACT + H_FRONT)) && (hcount_r < 10'(H_ACT + H_FRONT + H_SW)));
   assign vsync_raw  = !((vcount_r >= 10'(V_ACT + V_FRONT)) && (vcount_r < 10'(V_ACT + V_FRONT + V_SW)));
   assign active_raw = (hcount_r < 10'(H_ACT)) && (vcount_r < 10'(V_ACT));
   assign hcount     = hcount_r;
   assign vcount     = vcount_r;
   assign frame_tick = frame_tick_r;

endmodule

// File: rtl/pong_vga_renderer.sv
// Pong VGA renderer: per-frame game-state snapshot, sprite hit tests and registered video out.
// Optional score bars are built when PONG_SCORE_BARS_EN is defined.
module pong_vga_renderer
   import pong_pkg::*;
#(
   parameter int H_ACT   = H_ACTIVE,
   parameter int H_FRONT = H_FP,
   parameter int H_SW    = H_SYNC,
   parameter int H_BACK  = H_BP,
   parameter int V_ACT   = V_ACTIVE,
   parameter int V_FRONT = V_FP,
   parameter int V_SW    = V_SYNC,
   parameter int V_BACK  = V_BP
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pix_en,
   pong_vga_renderer_if.slave   game,
   output logic                 hsync,
   output logic                 vsync,
   output logic [5:0]           rgb,
   output logic                 display_on,
   output logic [9:0]           hpos,
   output logic [9:0]           vpos
);

   logic [9:0]  hcount_s;
   logic [9:0]  vcount_s;
   logic        hsync_raw_s;
   logic        vsync_raw_s;
   logic        active_raw_s;
   logic        snap_s;
   logic        frame_tick_s;
   game_state_t shadow_r;
   logic [10:0] h11_s;
   logic [10:0] v11_s;
   logic        left_hit_s;
   logic        right_hit_s;
   logic        ball_hit_s;
   logic        net_hit_s;
   logic [5:0]  pix_rgb_s;
   logic        hsync_r;
   logic        vsync_r;
   logic [5:0]  rgb_r;
   logic        display_on_r;

   vga_timing #(
      .H_ACT(H_ACT), .H_FRONT(H_FRONT), .H_SW(H_SW), .H_BACK(H_BACK),
      .V_ACT(V_ACT), .V_FRONT(V_FRONT), .V_SW(V_SW), .V_BACK(V_BACK)
   ) u_timing (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_en     (pix_en),
      .hcount     (hcount_s),
      .vcount     (vcount_s),
      .hsync_raw  (hsync_raw_s),
      .vsync_raw  (vsync_raw_s),
      .active_raw (active_raw_s),
      .snap       (snap_s),
      .frame_tick (frame_tick_s)
   );

   // Game state is latched only while entering vblank so a frame never tears.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_r <= {PADDLE_Y_RST, PADDLE_Y_RST, BALL_X_RST, BALL_Y_RST, 8'd0};
      end else if (pix_en && snap_s) begin
         shadow_r <= {game.player_paddle_y, game.opponent_paddle_y,
                      game.ball_x, game.ball_y, game.score};
      end
   end

   assign h11_s       = {1'b0, hcount_s};
   assign v11_s       = {1'b0, vcount_s};
   assign left_hit_s  = (h11_s < 11'(PADDLE_WIDTH)) &&
                        in_span(v11_s, {1'b0, shadow_r.opp_y}, 11'(PADDLE_HEIGHT));
   assign right_hit_s = (h11_s >= 11'(H_ACT - PADDLE_WIDTH)) &&
                        in_span(v11_s, {1'b0, shadow_r.ply_y}, 11'(PADDLE_HEIGHT));
   assign ball_hit_s  = in_span(h11_s, {1'b0, shadow_r.bx}, 11'(BALL_SIZE)) &&
                        in_span(v11_s, {1'b0, shadow_r.by}, 11'(BALL_SIZE));
   assign net_hit_s   = ((hcount_s == 10'(H_ACT / 2 - 1)) || (hcount_s == 10'(H_ACT / 2))) &&
                        !vcount_s[3];

`ifdef PONG_SCORE_BARS_EN
   logic bar_hit_s;
   assign bar_hit_s = (vcount_s >= 10'd8) && (vcount_s <= 10'd15) &&
                      ((h11_s < {4'd0, shadow_r.score[7:4], 3'b000}) ||
                       (h11_s >= (11'(H_ACT) - {4'd0, shadow_r.score[3:0], 3'b000})));
`else
   logic [7:0] unused_score_s;
   assign unused_score_s = shadow_r.score;
`endif

   // Colour priority, first match wins.
   always_comb begin
      pix_rgb_s = RGB_BLACK;
      if (!active_raw_s) begin
         pix_rgb_s = RGB_BLACK;
      end else if (ball_hit_s) begin
         pix_rgb_s = RGB_BALL;
`ifdef PONG_SCORE_BARS_EN
      end else if (bar_hit_s) begin
         pix_rgb_s = RGB_SCORE;
`endif
      end else if (left_hit_s || right_hit_s) begin
         pix_rgb_s = RGB_PADDLE;
      end else if (net_hit_s) begin
         pix_rgb_s = RGB_NET;
      end else begin
         pix_rgb_s = RGB_BLACK;
      end
   end

   // Sync and colour share one register stage so they stay aligned.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hsync_r      <= 1'b1;
         vsync_r      <= 1'b1;
         rgb_r        <= RGB_BLACK;
         display_on_r <= 1'b0;
      end else if (pix_en) begin
         hsync_r      <= hsync_raw_s;
         vsync_r      <= vsync_raw_s;
         rgb_r        <= pix_rgb_s;
         display_on_r <= active_raw_s;
      end
   end

   assign hsync           = hsync_r;
   assign vsync           = vsync_r;
   assign rgb             = rgb_r;
   assign display_on      = display_on_r;
   assign hpos            = hcount_s;
   assign vpos            = vcount_s;
   assign game.frame_tick = frame_tick_s;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Scoreboard bench for pong_vga_renderer; vertical timing shortened to 30 lines so several frames fit.
module tb_pong_vga_renderer;

   localparam int R     = 5;      // last reset cycle; edge k after release lands on cycle R+k
   localparam int FRAME = 24000;  // 800 x 30
   localparam int S     = 56401;  // cycle of the reset edge before the half-rate phase

   localparam int SIG_RGB = 0, SIG_HS = 1, SIG_VS = 2, SIG_DISP = 3,
                  SIG_TICK = 4, SIG_HPOS = 5, SIG_VPOS = 6;

`ifdef PONG_SCORE_BARS_EN
   localparam logic [5:0] BAR = 6'b001100;
`else
   localparam logic [5:0] BAR = 6'b000000;
`endif

   typedef struct {
      int         cyc;
      int         sig;
      logic [9:0] val;
      string      tag;
   } exp_t;

   exp_t sb_q[$];
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_mis = 0;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pix_en;
   logic       hsync;
   logic       vsync;
   logic [5:0] rgb;
   logic       display_on;
   logic [9:0] hpos;
   logic [9:0] vpos;

   pong_vga_renderer_if game_if ();

   pong_vga_renderer #(
      .V_ACT(24), .V_FRONT(2), .V_SW(2), .V_BACK(2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_en     (pix_en),
      .game       (game_if),
      .hsync      (hsync),
      .vsync      (vsync),
      .rgb        (rgb),
      .display_on (display_on),
      .hpos       (hpos),
      .vpos       (vpos)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_at(input int c, input int s, input logic [9:0] v, input string t);
      exp_t e;
      int   idx;
      e.cyc = c;
      e.sig = s;
      e.val = v;
      e.tag = t;
      idx   = sb_q.size();
      while (idx > 0 && sb_q[idx-1].cyc > c) idx--;
      sb_q.insert(idx, e);
   endtask

   function automatic int pk(input int h, input int v, input int f);
      return R + f * FRAME + v * 800 + h + 1;
   endfunction

   task automatic exp_rgb(input int h, input int v, input int f, input logic [5:0] c, input string t);
      expect_at(pk(h, v, f), SIG_RGB, {4'd0, c}, t);
   endtask

   function automatic logic [9:0] actual(input int s);
      case (s)
         SIG_RGB:  return {4'd0, rgb};
         SIG_HS:   return {9'd0, hsync};
         SIG_VS:   return {9'd0, vsync};
         SIG_DISP: return {9'd0, display_on};
         SIG_TICK: return {9'd0, game_if.frame_tick};
         SIG_HPOS: return hpos;
         SIG_VPOS: return vpos;
         default:  return 10'h3ff;
      endcase
   endfunction

   // Monitor: pops every expectation due on this cycle and compares.
   initial begin
      exp_t       e;
      logic [9:0] a;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            a = actual(e.sig);
            n_vec++;
            if (e.cyc != cyc) begin
               n_mis++;
               $display("FAIL %s: check for cycle %0d missed (now %0d)", e.tag, e.cyc, cyc);
            end else if (a !== e.val) begin
               n_mis++;
               $display("FAIL %s @cyc %0d: got %0h, expected %0h", e.tag, cyc, a, e.val);
            end
         end
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      pix_en = 1'b1;
      game_if.ball_x = 10'd100;
      game_if.ball_y = 10'd5;
      game_if.opponent_paddle_y = 10'd2;
      game_if.player_paddle_y = 10'd10;
      game_if.score = 8'h35;

      // reset state
      expect_at(4, SIG_HS, 10'd1, "rst_hsync");
      expect_at(4, SIG_VS, 10'd1, "rst_vsync");
      expect_at(4, SIG_RGB, 10'd0, "rst_rgb");
      expect_at(4, SIG_DISP, 10'd0, "rst_disp");
      expect_at(4, SIG_TICK, 10'd0, "rst_tick");
      expect_at(4, SIG_HPOS, 10'd0, "rst_hpos");
      expect_at(4, SIG_VPOS, 10'd0, "rst_vpos");
      // horizontal sync timing, period 800
      expect_at(R + 656, SIG_HS, 10'd1, "hs_before");
      expect_at(R + 657, SIG_HS, 10'd0, "hs_start");
      expect_at(R + 752, SIG_HS, 10'd0, "hs_last");
      expect_at(R + 753, SIG_HS, 10'd1, "hs_end");
      expect_at(R + 1456, SIG_HS, 10'd1, "hs2_before");
      expect_at(R + 1457, SIG_HS, 10'd0, "hs2_start");
      expect_at(R + 1000, SIG_HPOS, 10'd200, "hpos_1000");
      expect_at(R + 1000, SIG_VPOS, 10'd1, "vpos_1000");
      // active area edge
      expect_at(R + 1, SIG_DISP, 10'd1, "disp_first");
      expect_at(R + 640, SIG_DISP, 10'd1, "disp_last");
      expect_at(R + 641, SIG_DISP, 10'd0, "disp_off");
      // vertical sync lines 26..27 and frame strobe at (0,24)
      expect_at(R + 20800, SIG_VS, 10'd1, "vs_before");
      expect_at(R + 20801, SIG_VS, 10'd0, "vs_start");
      expect_at(R + 22400, SIG_VS, 10'd0, "vs_last");
      expect_at(R + 22401, SIG_VS, 10'd1, "vs_end");
      expect_at(R + 19199, SIG_TICK, 10'd0, "tick_pre");
      expect_at(R + 19200, SIG_TICK, 10'd1, "tick0");
      expect_at(R + 19201, SIG_TICK, 10'd0, "tick_post");
      expect_at(R + 19200, SIG_HPOS, 10'd0, "tick_hpos");
      expect_at(R + 19200, SIG_VPOS, 10'd24, "tick_vpos");
      expect_at(R + 43200, SIG_TICK, 10'd1, "tick1");
      // frame 0: reset shadows put ball/paddles off-screen, only the net shows
      exp_rgb(0, 0, 0, 6'b000000, "f0_origin");
      exp_rgb(319, 0, 0, 6'b010101, "f0_net319");
      exp_rgb(320, 5, 0, 6'b010101, "f0_net320");
      exp_rgb(319, 8, 0, 6'b000000, "f0_net_gap");
      exp_rgb(321, 0, 0, 6'b000000, "f0_net_right");
      // frame 1: ball (100,5), left paddle y=2, right paddle y=10, score 8'h35
      exp_rgb(100, 5, 1, 6'b111100, "ball_tl");
      exp_rgb(109, 14, 1, 6'b111100, "ball_br");
      exp_rgb(110, 5, 1, 6'b000000, "ball_right_out");
      exp_rgb(99, 5, 1, 6'b000000, "ball_left_out");
      exp_rgb(5, 2, 1, 6'b111111, "lpad_top");
      exp_rgb(5, 1, 1, 6'b000000, "lpad_above");
      exp_rgb(9, 20, 1, 6'b111111, "lpad_edge");
      exp_rgb(10, 20, 1, 6'b000000, "lpad_right_out");
      exp_rgb(630, 10, 1, 6'b111111, "rpad_top");
      exp_rgb(629, 3, 1, 6'b000000, "rpad_left_out");
      exp_rgb(639, 23, 1, 6'b111111, "rpad_corner");
      exp_rgb(320, 16, 1, 6'b010101, "f1_net");
      exp_rgb(15, 10, 1, BAR, "bar_opp");
      exp_rgb(24, 10, 1, 6'b000000, "bar_opp_end");
      exp_rgb(620, 12, 1, BAR, "bar_ply");
      exp_rgb(599, 10, 1, 6'b000000, "bar_ply_start");
      // ball_x changes mid frame 1; shows only from frame 2
      exp_rgb(100, 10, 1, 6'b111100, "snap_old_pos");
      exp_rgb(300, 10, 1, 6'b000000, "snap_new_early");
      exp_rgb(300, 10, 2, 6'b111100, "snap_new_pos");
      exp_rgb(100, 10, 2, 6'b000000, "snap_old_gone");
      // half-rate pix_en: enabled edges at S+1, S+3, ...
      expect_at(S, SIG_HPOS, 10'd0, "rst2_hpos");
      expect_at(S + 1312, SIG_HS, 10'd1, "hr_hs_before");
      expect_at(S + 1313, SIG_HS, 10'd0, "hr_hs_start");
      expect_at(S + 1314, SIG_HS, 10'd0, "hr_hs_hold");
      expect_at(S + 1314, SIG_HPOS, 10'd657, "hr_hpos_hold");
      expect_at(S + 1314, SIG_TICK, 10'd0, "hr_tick_low");
      expect_at(S + 1504, SIG_HS, 10'd0, "hr_hs_last");
      expect_at(S + 1505, SIG_HS, 10'd1, "hr_hs_end");
      expect_at(S + 2912, SIG_HS, 10'd1, "hr_hs2_before");
      expect_at(S + 2913, SIG_HS, 10'd0, "hr_hs2_start");
      expect_at(S + 2913, SIG_VPOS, 10'd1, "hr_vpos");
      expect_at(S + 3000, SIG_HS, 10'd0, "pre_rst_hs");
      expect_at(S + 3000, SIG_HPOS, 10'd700, "pre_rst_hpos");
      // mid-line reset with pix_en low
      expect_at(S + 3001, SIG_HPOS, 10'd0, "mrst_hpos");
      expect_at(S + 3001, SIG_VPOS, 10'd0, "mrst_vpos");
      expect_at(S + 3001, SIG_HS, 10'd1, "mrst_hsync");
      expect_at(S + 3001, SIG_VS, 10'd1, "mrst_vsync");
      expect_at(S + 3001, SIG_RGB, 10'd0, "mrst_rgb");
      expect_at(S + 3001, SIG_DISP, 10'd0, "mrst_disp");

      wait_cyc(R);
      rst_n = 1'b1;
      wait_cyc(pk(0, 3, 1));
      game_if.ball_x = 10'd300;
      wait_cyc(S - 1);
      rst_n = 1'b0;
      wait_cyc(S);
      rst_n = 1'b1;
      pix_en = 1'b1;
      while (cyc < S + 3000) begin
         @(negedge clk);
         if (cyc < S + 3000) pix_en = ((cyc - S) % 2 == 0);
      end
      rst_n = 1'b0;
      pix_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);

      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         n_vec++;
         n_mis++;
         $display("FAIL %s: check for cycle %0d never reached", e.tag, e.cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/pong_vga_renderer.md
Name: pong_vga_renderer

Overview:
- Downstream consumer of the pong game core. Generates 640x480@60 VGA timing and renders paddles, ball and centre net from the core's position outputs.
- Drives the TinyTapeout VGA PMOD: 2-bit R/G/B plus hsync and vsync.
- Emits a once-per-frame strobe so the game core can step its update at vertical blank.
- Snapshots the game state once per frame, so an image never tears mid-frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width (frame total 525)
- PADDLE_WIDTH, 10, paddle width in px
- PADDLE_HEIGHT, 60, paddle height in px
- BALL_SIZE, 10, ball square side in px

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pix_en  in  1  pixel-rate enable; all state advances only when high
- player_paddle_y  in  10  top y of right paddle
- opponent_paddle_y  in  10  top y of left paddle
- ball_x  in  10  ball left x
- ball_y  in  10  ball top y
- score  in  8  [7:4] opponent, [3:0] player
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- rgb  out  6  {R[1:0],G[1:0],B[1:0]}
- display_on  out  1  high when the registered pixel is in the active area
- frame_tick  out  1  one-clk pulse at the start of vertical blank
- hpos  out  10  current column counter (unregistered view)
- vpos  out  10  current line counter (unregistered view)

Behaviour:
- Reset is synchronous, active-low, on clk; rst_n is sampled regardless of pix_en.
- Reset values: hcount=0, vcount=0, hsync=1, vsync=1, rgb=0, display_on=0, frame_tick=0.
- Shadow registers reset to ball (320,240) and both paddles to 210. Reset mid-frame restarts the frame at (0,0).
- Counters advance only on a clk edge with pix_en=1:
  - hcount runs 0..799 and wraps to 0.
  - vcount increments when hcount wraps and runs 0..524 before wrapping to 0.
  - With pix_en=0, all registers hold and frame_tick=0.
- Raw sync (before the output register):
  - hsync_raw is low iff hcount is in [656,751].
  - vsync_raw is low iff vcount is in [490,491].
  - active_raw = hcount<640 && vcount<480.
- Snapshot and frame strobe:
  - On the pix_en edge where the counter moves to (h=0, v=480), latch all five game inputs into shadow registers.
  - frame_tick pulses high for exactly that one clk cycle.
- Hit tests use the shadow registers and 11-bit zero-extended sums, so y+PADDLE_HEIGHT cannot wrap:
  - left paddle: h<PADDLE_WIDTH && opp_y<=v<opp_y+PADDLE_HEIGHT
  - right paddle: h>=H_ACTIVE-PADDLE_WIDTH && ply_y<=v<ply_y+PADDLE_HEIGHT
  - ball: bx<=h<bx+BALL_SIZE && by<=v<by+BALL_SIZE
  - net: h in {319,320} && v[3]==0
- Colour priority (first match wins): ball = 6'b111100 (yellow); paddle = 6'b111111; net = 6'b010101; else 0.
- Outside the active area, rgb is forced to 0.
- Pipeline: hsync, vsync, rgb and display_on are registered together on pix_en. Latency is 1 pix_en tick from the counter value, so sync and colour stay mutually aligned.
- Out-of-range inputs (e.g. ball_x>639) are not clipped; pixels simply fall off screen.

Optional Feature:
- Macro: PONG_SCORE_BARS_EN.
- With the macro defined: in lines 8..15, draw opponent score bar at h < 8*score[7:4] and player bar at h >= 640-8*score[3:0], colour 6'b001100 (green). Priority is just below ball.
- Without the macro: the score input is unused and no bars are drawn.

Decomposition:
- Package pong_pkg holds:
  - VGA timing localparams (totals and sync start/end derived from the porches)
  - colour constants
  - PADDLE_/BALL_ geometry defaults, shared with the game core
- One sub-module, vga_timing: counters, raw sync, active_raw and frame_tick generation.
- pong_vga_renderer instantiates vga_timing and adds the snapshot, hit tests and output register.

Test Plan:
- Reset, pix_en=1 continuously -> hsync low for 96 clks starting 657 clks after reset release (1-tick latency), period 800.
- Same run -> vsync low for exactly 1600 clks (lines 490-491); frame period 420000 clks; frame_tick every 420000 clks.
- Ball (100,50), paddles 210 -> pixel (100,50) and (109,59) yellow, (110,50) black; (5,210) white, (5,270) black; (635,269) white.
- Change ball_x 100→300 while vcount=100 -> rest of frame still draws at x=100; after the next frame_tick, the next frame draws at x=300.
- pix_en high every other clk -> line period 1600 clks; no output changes on pix_en=0 cycles; assert rst_n=0 mid-line -> hcount=vcount=0, hsync=vsync=1, rgb=0 next clk.
- PONG_SCORE_BARS_EN, score=8'h35 -> line 10: green for h 0..23 and h 600..639 (except paddle/ball overlap); without macro, black there.
